// File: rtl/pipeline_ctrl.sv
// Stall and flush controller for the 5-stage 16-bit pipeline.
// Drives the PC and pipeline-register enables and flushes. Handles load-use
// bubbles, taken-branch squashes, external memory wait and the HLT
// drain/halt/resume sequence. Also keeps a saturating stall-cycle counter.
module pipeline_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memread_ex,
  input  logic [2:0]       rd_ex,
  input  logic [2:0]       rs_id,
  input  logic [2:0]       rt_id,
  input  logic             use_rs_id,
  input  logic             use_rt_id,
  input  logic             branch_taken_ex,
  input  logic             halt_id,
  input  logic             mem_busy,
  input  logic             resume,
  output logic             en_pc,
  output logic             en_ifid,
  output logic             en_idex,
  output logic             en_exmem,
  output logic             en_memwb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic             flush_memwb,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  // The drain counter is loaded with one less than the drain length, so
  // reaching zero marks the final cycle spent in DRAIN.
  localparam logic [1:0]       DRAIN_LOAD = 2'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_e           state_q, state_d;
  logic [1:0]       drain_cnt_q, drain_cnt_d;
  logic             resume_q;
  logic             resume_pend_q, resume_pend_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic resume_edge;
  logic resume_go;

  assign load_use    = memread_ex & ((use_rs_id & (rs_id == rd_ex)) |
                                     (use_rt_id & (rt_id == rd_ex)));
  assign resume_edge = resume & ~resume_q;
  assign resume_go   = (resume_edge | resume_pend_q) & ~mem_busy;
  assign stall_cnt   = stall_cnt_q;

  // State register, plus the drain counter, resume tracking and stall counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= RUN;
      drain_cnt_q   <= 2'd0;
      resume_q      <= 1'b0;
      resume_pend_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      resume_q      <= resume;
      resume_pend_q <= resume_pend_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  // Next-state logic: enter DRAIN on HLT, count the drain down, park in
  // HALTED, and leave it on a resume edge that memory is free to accept.
  always_comb begin
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;
    resume_pend_d = resume_pend_q;
    case (state_q)
      RUN: begin
        if (!mem_busy && !branch_taken_ex && !load_use && halt_id) begin
          state_d     = DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        if (mem_busy) begin
          drain_cnt_d = drain_cnt_q;
        end else if (branch_taken_ex) begin
          state_d     = RUN;
          drain_cnt_d = 2'd0;
        end else if (drain_cnt_q == 2'd0) begin
          state_d = HALTED;
        end else begin
          drain_cnt_d = drain_cnt_q - 2'd1;
        end
      end
      HALTED: begin
        if (resume_go) begin
          state_d       = RUN;
          resume_pend_d = 1'b0;
        end else if (resume_edge) begin
          resume_pend_d = 1'b1;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Mealy outputs: enables and flushes from current state and hazard inputs.
  always_comb begin
    en_pc       = 1'b0;
    en_ifid     = 1'b0;
    en_idex     = 1'b0;
    en_exmem    = 1'b0;
    en_memwb    = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    flush_memwb = 1'b0;
    halted      = 1'b0;
    if (!reset) begin
      flush_ifid  = 1'b1;
      flush_idex  = 1'b1;
      flush_exmem = 1'b1;
      flush_memwb = 1'b1;
    end else begin
      case (state_q)
        RUN, DRAIN: begin
          if (mem_busy) begin
            en_pc = 1'b0;
          end else if (branch_taken_ex) begin
            en_pc      = 1'b1;
            en_ifid    = 1'b1;
            en_idex    = 1'b1;
            en_exmem   = 1'b1;
            en_memwb   = 1'b1;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
          end else if (state_q == DRAIN || load_use || halt_id) begin
            en_idex    = 1'b1;
            flush_idex = 1'b1;
            en_exmem   = 1'b1;
            en_memwb   = 1'b1;
          end else begin
            en_pc    = 1'b1;
            en_ifid  = 1'b1;
            en_idex  = 1'b1;
            en_exmem = 1'b1;
            en_memwb = 1'b1;
          end
        end
        HALTED: begin
          halted = 1'b1;
          if (resume_go) begin
            en_pc      = 1'b1;
            en_ifid    = 1'b1;
            en_idex    = 1'b1;
            en_exmem   = 1'b1;
            en_memwb   = 1'b1;
            flush_ifid = 1'b1;
          end
        end
        default: begin
          halted = 1'b0;
        end
      endcase
    end
  end

  // Stall counter: counts frozen-PC cycles outside HALTED and sticks at max.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q != HALTED && !en_pc && stall_cnt_q != CNT_MAX) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed vectors push hand-computed
// expected outputs into a queue, and a negedge monitor pops and compares.
module tb_pipeline_ctrl;

  logic        clk;
  logic        reset;
  logic        memread_ex;
  logic [2:0]  rd_ex;
  logic [2:0]  rs_id;
  logic [2:0]  rt_id;
  logic        use_rs_id;
  logic        use_rt_id;
  logic        branch_taken_ex;
  logic        halt_id;
  logic        mem_busy;
  logic        resume;
  logic        en_pc, en_ifid, en_idex, en_exmem, en_memwb;
  logic        flush_ifid, flush_idex, flush_exmem, flush_memwb;
  logic        halted;
  logic [15:0] stall_cnt;

  // Bit order: en_pc en_ifid en_idex en_exmem en_memwb
  //            flush_ifid flush_idex flush_exmem flush_memwb halted
  localparam logic [9:0] RUN_O = 10'b11111_0000_0;
  localparam logic [9:0] FRZ_O = 10'b00000_0000_0;
  localparam logic [9:0] BR_O  = 10'b11111_1100_0;
  localparam logic [9:0] BUB_O = 10'b00011_0100_0;
  localparam logic [9:0] RST_O = 10'b00000_1111_0;
  localparam logic [9:0] HLT_O = 10'b00000_0000_1;
  localparam logic [9:0] RES_O = 10'b11111_1000_1;
  localparam logic [9:0] ALL_M = 10'b11111_1111_1;
  localparam logic [9:0] BUB_M = 10'b11011_1111_1;

  typedef struct {
    string       name;
    logic [9:0]  outs;
    logic [9:0]  mask;
    logic [15:0] stall;
  } exp_t;

  exp_t        sb[$];
  int          checks;
  int          fails;
  logic [15:0] stallModel;

  pipeline_ctrl #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .memread_ex(memread_ex), .rd_ex(rd_ex), .rs_id(rs_id), .rt_id(rt_id),
    .use_rs_id(use_rs_id), .use_rt_id(use_rt_id),
    .branch_taken_ex(branch_taken_ex), .halt_id(halt_id),
    .mem_busy(mem_busy), .resume(resume),
    .en_pc(en_pc), .en_ifid(en_ifid), .en_idex(en_idex),
    .en_exmem(en_exmem), .en_memwb(en_memwb),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .flush_exmem(flush_exmem), .flush_memwb(flush_memwb),
    .halted(halted), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Quiet pipeline: no hazards, no wait, reset released.
  task automatic setIdle();
    reset           = 1'b1;
    memread_ex      = 1'b0;
    rd_ex           = 3'd0;
    rs_id           = 3'd0;
    rt_id           = 3'd0;
    use_rs_id       = 1'b0;
    use_rt_id       = 1'b0;
    branch_taken_ex = 1'b0;
    halt_id         = 1'b0;
    mem_busy        = 1'b0;
    resume          = 1'b0;
  endtask

  // Records the expectation for the cycle whose inputs are already driven,
  // advances the stall-count model, then moves to just after the next edge.
  task automatic applyStimulus(input string name, input logic [9:0] outs,
                               input logic [9:0] mask);
    exp_t e;
    e.name  = name;
    e.outs  = outs;
    e.mask  = mask;
    e.stall = stallModel;
    sb.push_back(e);
    if (!reset) begin
      stallModel = 16'd0;
    end else if (!outs[9] && !outs[0] && stallModel != 16'hFFFF) begin
      stallModel = stallModel + 16'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input exp_t e);
    logic [9:0] act;
    act = {en_pc, en_ifid, en_idex, en_exmem, en_memwb,
           flush_ifid, flush_idex, flush_exmem, flush_memwb, halted};
    checks++;
    if ((act & e.mask) !== (e.outs & e.mask)) begin
      fails++;
      $display("[TB] FAIL %s outputs: got %b expected %b (mask %b)",
               e.name, act, e.outs, e.mask);
    end
    checks++;
    if (stall_cnt !== e.stall) begin
      fails++;
      $display("[TB] FAIL %s stall_cnt: got %0d expected %0d",
               e.name, stall_cnt, e.stall);
    end
  endtask

  // Monitor: compares whatever expectation is pending for the current cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) checkOutput(sb.pop_front());
    end
  end

  initial begin
    checks     = 0;
    fails      = 0;
    stallModel = 16'd0;
    setIdle();
    reset = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus("reset_hold", RST_O, ALL_M);

    // Load-use and branch priority
    setIdle();
    applyStimulus("idle", RUN_O, ALL_M);
    memread_ex = 1'b1; rd_ex = 3'd2; rs_id = 3'd2; use_rs_id = 1'b1;
    applyStimulus("lu_rs", BUB_O, BUB_M);
    memread_ex = 1'b0;
    applyStimulus("lu_bubble", RUN_O, ALL_M);
    memread_ex = 1'b1; use_rs_id = 1'b0; use_rt_id = 1'b1; rt_id = 3'd5;
    applyStimulus("lu_unused_rs", RUN_O, ALL_M);
    rt_id = 3'd2;
    applyStimulus("lu_rt", BUB_O, BUB_M);
    use_rs_id = 1'b1; branch_taken_ex = 1'b1;
    applyStimulus("branch_over_lu", BR_O, ALL_M);
    mem_busy = 1'b1;
    applyStimulus("busy_over_branch", FRZ_O, ALL_M);
    setIdle();
    applyStimulus("idle2", RUN_O, ALL_M);

    // Halt, then resume edge while memory is busy
    halt_id = 1'b1;
    applyStimulus("halt_issue", BUB_O, BUB_M);
    applyStimulus("drain1", BUB_O, BUB_M);
    applyStimulus("drain2", BUB_O, BUB_M);
    applyStimulus("drain3", BUB_O, BUB_M);
    applyStimulus("halted1", HLT_O, ALL_M);
    branch_taken_ex = 1'b1;
    applyStimulus("halted_ignore_br", HLT_O, ALL_M);
    branch_taken_ex = 1'b0;
    resume = 1'b1; mem_busy = 1'b1;
    applyStimulus("resume_busy1", HLT_O, ALL_M);
    applyStimulus("resume_busy2", HLT_O, ALL_M);
    applyStimulus("resume_busy3", HLT_O, ALL_M);
    mem_busy = 1'b0;
    applyStimulus("resume_pend_go", RES_O, ALL_M);
    halt_id = 1'b0;
    applyStimulus("after_resume", RUN_O, ALL_M);
    resume = 1'b0;
    applyStimulus("idle3", RUN_O, ALL_M);

    // Halt with a memory wait inside the drain, then an immediate resume edge
    halt_id = 1'b1;
    applyStimulus("halt2_issue", BUB_O, BUB_M);
    applyStimulus("drain2_1", BUB_O, BUB_M);
    mem_busy = 1'b1;
    applyStimulus("drain2_busy", FRZ_O, ALL_M);
    mem_busy = 1'b0;
    applyStimulus("drain2_2", BUB_O, BUB_M);
    applyStimulus("drain2_3", BUB_O, BUB_M);
    applyStimulus("halted2", HLT_O, ALL_M);
    resume = 1'b1;
    applyStimulus("resume_edge_go", RES_O, ALL_M);
    halt_id = 1'b0;
    applyStimulus("after_resume2", RUN_O, ALL_M);
    resume = 1'b0;

    // Wrong-path halt squashed by a taken branch
    halt_id = 1'b1;
    applyStimulus("wp_halt", BUB_O, BUB_M);
    branch_taken_ex = 1'b1;
    applyStimulus("wp_branch", BR_O, ALL_M);
    setIdle();
    applyStimulus("wp_run1", RUN_O, ALL_M);
    applyStimulus("wp_run2", RUN_O, ALL_M);

    // Reset mid-DRAIN
    halt_id = 1'b1;
    applyStimulus("rst_halt", BUB_O, BUB_M);
    applyStimulus("rst_drain", BUB_O, BUB_M);
    reset = 1'b0;
    applyStimulus("rst_mid_drain", RST_O, ALL_M);
    setIdle();
    applyStimulus("rst_back_run", RUN_O, ALL_M);

    // Stall counter saturation
    mem_busy = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    stallModel = 16'hFFFF;
    applyStimulus("sat1", FRZ_O, ALL_M);
    applyStimulus("sat2", FRZ_O, ALL_M);
    setIdle();
    applyStimulus("sat_release", RUN_O, ALL_M);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
